// File: rtl/mips_dmem_responder_if.sv
// Request/response bus between a MIPS core's data port and the data memory responder.
interface mips_dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mips_dmem_responder.sv
// Single-outstanding data memory responder with fixed accept-to-response latency.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | ready for a request; req_ready high
//   S_WAIT | request latched, latency down-counter running
//   S_RESP | memory op done, response held until rsp_ready
module mips_dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  mips_dmem_responder_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        r_state;
  logic [2:0]    r_cnt;
  logic          r_req_ready;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_rdata;
  logic          r_rsp_err;

  logic          r_we;
  logic          r_err;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;

  logic [31:0]   r_mem [DEPTH];

  logic          w_accept;
  logic          w_in_err;
  logic [AW-1:0] w_in_idx;
  logic          w_op_we;
  logic          w_op_err;
  logic [AW-1:0] w_op_idx;
  logic [31:0]   w_op_wdata;
  logic [3:0]    w_op_be;
  logic          w_do_op;
  logic          w_mem_we;
  logic [31:0]   w_old;
  logic [31:0]   w_merged;
  logic [31:0]   w_op_rdata;

  assign w_accept = r_req_ready && bus.req_valid;
  assign w_in_err = (bus.req_addr[1:0] != 2'b00) || ((bus.req_addr >> (AW + 2)) != 32'd0);
  assign w_in_idx = bus.req_addr[AW+1:2];

  // With LATENCY=1 the operation happens on the accept edge, so it must use the
  // live request; otherwise it uses the copy latched at accept.
  assign w_op_we    = (r_state == S_IDLE) ? bus.req_we    : r_we;
  assign w_op_err   = (r_state == S_IDLE) ? w_in_err      : r_err;
  assign w_op_idx   = (r_state == S_IDLE) ? w_in_idx      : r_idx;
  assign w_op_wdata = (r_state == S_IDLE) ? bus.req_wdata : r_wdata;
  assign w_op_be    = (r_state == S_IDLE) ? bus.req_be    : r_be;

  assign w_do_op  = (w_accept && (LATENCY == 1)) || ((r_state == S_WAIT) && (r_cnt == 3'd0));
  // rst_n gating keeps an aborted store out of memory even on the reset edge.
  assign w_mem_we = rst_n && w_do_op && w_op_we && !w_op_err;

  assign w_old      = r_mem[w_op_idx];
  assign w_op_rdata = (w_op_err || w_op_we) ? 32'd0 : w_old;

  // Byte-enable merge of store data over the current word.
  always_comb begin
    w_merged = w_old;
    for (int b = 0; b < 4; b++) begin
      if (w_op_be[b]) w_merged[8*b +: 8] = w_op_wdata[8*b +: 8];
    end
  end

  // Storage array; deliberately not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_op_idx] <= w_merged;
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_idx       <= '0;
      r_wdata     <= 32'd0;
      r_be        <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we        <= bus.req_we;
            r_err       <= w_in_err;
            r_idx       <= w_in_idx;
            r_wdata     <= bus.req_wdata;
            r_be        <= bus.req_be;
            r_req_ready <= 1'b0;
            if (LATENCY == 1) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_op_rdata;
              r_rsp_err   <= w_op_err;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_op_rdata;
            r_rsp_err   <= w_op_err;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cnt       <= 3'd0;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

endmodule
